// File: rtl/dnn_hex_pkg.sv
// Shared constants for the multi-digit seven-segment display controller.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
//
// Contents: Avalon word-address map, the active-low "dark" segment code and
// the active-high hex-digit decode table (bit order gfedcba).
package dnn_hex_pkg;

  // Word addresses on the 4-bit Avalon address bus.
  localparam logic [3:0] ADDR_VALUE    = 4'd0;
  localparam logic [3:0] ADDR_MODE     = 4'd1;
  localparam logic [3:0] ADDR_BLANK    = 4'd2;
  localparam logic [3:0] ADDR_BLINK    = 4'd3;
  localparam logic [3:0] ADDR_RAW_BASE = 4'd8;

  // All segments off on an active-low display.
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-high segment patterns for 0..F; entry 0 sits in the low bits.
  localparam logic [15:0][6:0] SEG_DECODE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    return SEG_DECODE[nibble];
  endfunction

endpackage

// File: rtl/hex_seg_decoder.sv
// Hex nibble to seven-segment pattern decoder.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input continuously.
//
// Ports:
//   nibble  in  4  hex value 0..F
//   seg     out 7  active-high segment pattern, bit order gfedcba
module hex_seg_decoder
  import dnn_hex_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = seg_decode(nibble);

endmodule

// File: rtl/dnn_accel_hex_display.sv
// Avalon-MM slave driving up to eight active-low seven-segment digits.
// Latency: register write visible on readdata right after the write edge,
//          on hex_out one edge later; zero-wait-state combinational reads.
// Backpressure: none; the slave accepts every access in the cycle it is presented.
//
// Optional feature: define DNN_HEX_BLINK_EN to build the BLINK register and
// the blink counter/phase. Without it BLINK reads 0, ignores writes, and the
// blink phase is held at 0.
//
// Ports:
//   clk         in   1             system clock
//   reset_n     in   1             synchronous active-low reset
//   address     in   4             word address
//   chipselect  in   1             slave select
//   write_n     in   1             active-low write strobe
//   writedata   in   32            write data
//   readdata    out  32            combinational read data for address
//   hex_out     out  7*NUM_DIGITS  registered active-low segments, digit i at [7i+6:7i]
module dnn_accel_hex_display
  import dnn_hex_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [3:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [7*NUM_DIGITS-1:0] hex_out
);

  // Reject illegal parameterisations at elaboration time.
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || BLINK_DIV < 2) begin : g_bad_param
    $error("dnn_accel_hex_display: NUM_DIGITS must be 1..8 and BLINK_DIV >= 2");
  end

  // Register file. Only the implemented digits get storage, so bits for
  // digits >= NUM_DIGITS naturally read 0 and drop writes.
  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   mode_q;
  logic [NUM_DIGITS-1:0]   blank_q;
  logic [6:0]              raw_q [NUM_DIGITS];

  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    blink_phase;

  logic                    wr_en;
  logic [6:0]              dec_seg [NUM_DIGITS];
  logic [7*NUM_DIGITS-1:0] hex_nxt;
  logic [6:0]              pat;

  // Upper writedata bits are only meaningful for some NUM_DIGITS values.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  assign wr_en = chipselect && !write_n;

  // --------------------------------------------------------------------------
  // Control/status registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      value_q <= '0;
      mode_q  <= '0;
      blank_q <= '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        raw_q[i] <= '0;
      end
    end else if (wr_en) begin
      case (address)
        ADDR_VALUE: value_q <= writedata[4*NUM_DIGITS-1:0];
        ADDR_MODE:  mode_q  <= writedata[NUM_DIGITS-1:0];
        ADDR_BLANK: blank_q <= writedata[NUM_DIGITS-1:0];
        default: ;
      endcase
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (address == ADDR_RAW_BASE + 4'(i)) begin
          raw_q[i] <= writedata[6:0];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Blink timer
  // --------------------------------------------------------------------------
`ifdef DNN_HEX_BLINK_EN
  localparam int CNT_W = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  logic [NUM_DIGITS-1:0] blink_q;
  logic [CNT_W-1:0]      blink_cnt;
  logic                  phase_q;

  // A BLINK write restarts the period in the visible half; it takes priority
  // over a wrap in the same cycle so freshly enabled digits never start dark.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blink_q   <= '0;
      blink_cnt <= '0;
      phase_q   <= 1'b0;
    end else if (wr_en && address == ADDR_BLINK) begin
      blink_q   <= writedata[NUM_DIGITS-1:0];
      blink_cnt <= '0;
      phase_q   <= 1'b0;
    end else if (blink_cnt == CNT_MAX) begin
      blink_cnt <= '0;
      phase_q   <= ~phase_q;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign blink_mask  = blink_q;
  assign blink_phase = phase_q;
`else
  assign blink_mask  = '0;
  assign blink_phase = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Per-digit pattern selection and registered output
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    hex_seg_decoder u_dec (
      .nibble (value_q[4*g +: 4]),
      .seg    (dec_seg[g])
    );
  end

  // Later assignments override earlier ones, so the order below runs from
  // lowest to highest priority: decode, raw, blink-dark, blank.
  always_comb begin
    hex_nxt = '1;
    pat     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      pat = dec_seg[i];
      if (mode_q[i]) begin
        pat = raw_q[i];
      end
      if (blink_mask[i] && blink_phase) begin
        pat = '0;
      end
      if (blank_q[i]) begin
        pat = '0;
      end
      hex_nxt[7*i +: 7] = ~pat;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hex_out <= {NUM_DIGITS{SEG_OFF}};
    end else begin
      hex_out <= hex_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Read mux: combinational, independent of chipselect
  // --------------------------------------------------------------------------
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_VALUE: readdata = 32'(value_q);
      ADDR_MODE:  readdata = 32'(mode_q);
      ADDR_BLANK: readdata = 32'(blank_q);
      ADDR_BLINK: readdata = 32'(blink_mask);
      default:    readdata = '0;
    endcase
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (address == ADDR_RAW_BASE + 4'(i)) begin
        readdata = {25'd0, raw_q[i]};
      end
    end
  end

endmodule

// File: tb/tb_dnn_accel_hex_display.sv
module tb_dnn_accel_hex_display;

  localparam int ND  = 6;
  localparam int DIV = 4;
  localparam int HW  = 7 * ND;

`ifdef DNN_HEX_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [3:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [HW-1:0] hex_out;

  int checks = 0;
  int errors = 0;

  dnn_accel_hex_display #(.NUM_DIGITS(ND), .BLINK_DIV(DIV)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .hex_out    (hex_out)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [6:0]    dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [6:0]    spec_digits [ND] = '{7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [31:0]   m_value, m_mode, m_blank, m_blink;
  logic [6:0]    m_raw [ND];
  int            m_k;        // edges since the blink period last restarted
  logic [HW-1:0] exp_hex;

  function automatic bit model_phase();
    return BLINK_EN && (((m_k / DIV) % 2) == 1);
  endfunction

  function automatic logic [HW-1:0] model_hex();
    logic [HW-1:0] r;
    logic [6:0]    p;
    for (int i = 0; i < ND; i++) begin
      if (m_blank[i])                       p = 7'h00;
      else if (m_blink[i] && model_phase()) p = 7'h00;
      else if (m_mode[i])                   p = m_raw[i];
      else                                  p = dec_tab[(m_value >> (4 * i)) & 32'hF];
      r[7*i +: 7] = ~p;
    end
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    int ai;
    ai = int'(a);
    if (ai == 0) return m_value;
    if (ai == 1) return m_mode;
    if (ai == 2) return m_blank;
    if (ai == 3) return m_blink;
    if (ai >= 8 && ai < 8 + ND) return {25'd0, m_raw[ai - 8]};
    return 32'd0;
  endfunction

  task automatic model_reset();
    m_value = 0;
    m_mode  = 0;
    m_blank = (32'd1 << ND) - 1;
    m_blink = 0;
    for (int i = 0; i < ND; i++) m_raw[i] = 7'd0;
    m_k = 0;
  endtask

  task automatic model_write(input logic [3:0] a, input logic [31:0] d);
    int   ai;
    logic [31:0] dmask;
    ai    = int'(a);
    dmask = (32'd1 << ND) - 1;
    if (ai == 0) m_value = d & ((32'd1 << (4 * ND)) - 1);
    if (ai == 1) m_mode  = d & dmask;
    if (ai == 2) m_blank = d & dmask;
    if (ai == 3 && BLINK_EN) m_blink = d & dmask;
    if (ai >= 8 && ai < 8 + ND) m_raw[ai - 8] = d[6:0];
  endtask

  // Advance one clock edge, updating the model with what the DUT samples.
  task automatic step();
    logic [HW-1:0] nxt;
    bit wr;
    nxt = model_hex();
    wr  = chipselect && !write_n;
    if (!reset_n) begin
      nxt = '1;
      model_reset();
    end else begin
      if (wr) model_write(address, writedata);
      if (wr && address == 4'd3 && BLINK_EN) m_k = 0;
      else m_k++;
    end
    @(posedge clk);
    #1;
    exp_hex = nxt;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
    checks++;
    if (hex_out !== {HW{1'b1}}) begin
      errors++;
      $display("FAIL reset_hex: got %h expected %h", hex_out, {HW{1'b1}});
    end
    address = 4'd2;
    #1;
    checks++;
    if (readdata !== 32'h3F) begin
      errors++;
      $display("FAIL reset_blank_read: got %h expected %h", readdata, 32'h3F);
    end
    for (int a = 0; a < 16; a++) begin
      address = 4'(a);
      #1;
      checks++;
      if (readdata !== model_read(4'(a))) begin
        errors++;
        $display("FAIL reset_read[%0d]: got %h expected %h", a, readdata, model_read(4'(a)));
      end
    end
  endtask

  task automatic test_decode();
    wr(4'd2, 32'h0);
    wr(4'd0, 32'h00FEDCBA);
    step();
    for (int i = 0; i < ND; i++) begin
      checks++;
      if (hex_out[7*i +: 7] !== spec_digits[i]) begin
        errors++;
        $display("FAIL decode_digit[%0d]: got %h expected %h", i, hex_out[7*i +: 7], spec_digits[i]);
      end
    end
    checks++;
    if (hex_out !== exp_hex) begin
      errors++;
      $display("FAIL decode_model: got %h expected %h", hex_out, exp_hex);
    end
  endtask

  task automatic test_raw();
    wr(4'd10, 32'h49);
    wr(4'd1, 32'h04);
    step();
    for (int i = 0; i < ND; i++) begin
      checks++;
      if (hex_out[7*i +: 7] !== ((i == 2) ? 7'h36 : spec_digits[i])) begin
        errors++;
        $display("FAIL raw_digit[%0d]: got %h expected %h", i, hex_out[7*i +: 7],
                 (i == 2) ? 7'h36 : spec_digits[i]);
      end
    end
    wr(4'd14, 32'h7F);
    address = 4'd14;
    #1;
    checks++;
    if (readdata !== 32'd0) begin
      errors++;
      $display("FAIL raw_beyond_digits: got %h expected %h", readdata, 32'd0);
    end
    checks++;
    if (hex_out !== exp_hex) begin
      errors++;
      $display("FAIL raw_beyond_hex: got %h expected %h", hex_out, exp_hex);
    end
  endtask

  task automatic test_blink();
    wr(4'd3, 32'h01);
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (hex_out !== exp_hex) begin
        errors++;
        $display("FAIL blink_run[%0d]: got %h expected %h", c, hex_out, exp_hex);
      end
      step();
    end
    // Now in the dark half (when the timer exists); restart it.
    wr(4'd3, 32'h01);
    for (int c = 0; c < 14; c++) begin
      checks++;
      if (hex_out !== exp_hex) begin
        errors++;
        $display("FAIL blink_restart[%0d]: got %h expected %h", c, hex_out, exp_hex);
      end
      step();
    end
    wr(4'd3, 32'hFF);
    address = 4'd3;
    #1;
    checks++;
    if (readdata !== model_read(4'd3)) begin
      errors++;
      $display("FAIL blink_read: got %h expected %h", readdata, model_read(4'd3));
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 300; n++) begin
      logic [3:0] a;
      a = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      address    = a;
      writedata  = $urandom;
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = ($urandom_range(0, 2) == 0);
      #1;
      checks++;
      if (readdata !== model_read(a)) begin
        errors++;
        $display("FAIL rand_read[%0d] addr %0d: got %h expected %h", n, a, readdata, model_read(a));
      end
      step();
      checks++;
      if (hex_out !== exp_hex) begin
        errors++;
        $display("FAIL rand_hex[%0d]: got %h expected %h", n, hex_out, exp_hex);
      end
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic test_reset_mid();
    wr(4'd0, 32'h12345678);
    wr(4'd1, 32'h2A);
    wr(4'd9, 32'h55);
    wr(4'd3, 32'h3F);
    wr(4'd2, 32'h0);
    repeat (5) step();
    reset_n    = 1'b0;
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = 4'd2;
    writedata  = 32'h0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
    checks++;
    if (hex_out !== {HW{1'b1}}) begin
      errors++;
      $display("FAIL midreset_hex: got %h expected %h", hex_out, {HW{1'b1}});
    end
    reset_n = 1'b1;
    for (int a = 0; a < 16; a++) begin
      address = 4'(a);
      #1;
      checks++;
      if (readdata !== model_read(4'(a))) begin
        errors++;
        $display("FAIL midreset_read[%0d]: got %h expected %h", a, readdata, model_read(4'(a)));
      end
    end
    step();
    checks++;
    if (hex_out !== {HW{1'b1}}) begin
      errors++;
      $display("FAIL midreset_hold_hex: got %h expected %h", hex_out, {HW{1'b1}});
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 4'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    model_reset();
    exp_hex    = '1;
    test_reset();
    test_decode();
    test_raw();
    test_blink();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dnn_accel_hex_display.md
# dnn_accel_hex_display

Memory-mapped multi-digit seven-segment display controller: an Avalon-MM slave on the Nios II system bus that drives up to eight active-low HEX displays. It generalises the single-register raw-segment PIO. Digit count is a parameter. Each digit is selectable between hex-nibble decode and raw segment mode, with per-digit blanking and an optional hardware blink timer.

## Interface
- NUM_DIGITS, 6, number of driven digits; legal 1..8
- BLINK_DIV, 25000000, clk cycles per blink half-period; legal ≥ 2

- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset, sampled on rising clk
- address  in  4  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe; write occurs when chipselect && !write_n
- writedata  in  32  write data
- readdata  out  32  combinational read data for current address; zero wait states
- hex_out  out  7*NUM_DIGITS  registered segment outputs, active-low. Digit i occupies [7i+6:7i], bit order gfedcba.

## Operation
- Register map (word address):
  - 0 VALUE: nibble i = hex value for digit i.
  - 1 MODE: bit i = 1 selects raw mode for digit i.
  - 2 BLANK: bit i = 1 forces digit i dark.
  - 3 BLINK: bit i = 1 blinks digit i.
  - 8+i RAW_i: bits [6:0] hold the active-high segment pattern for digit i.
  - Addresses 4–7, 8+NUM_DIGITS..15: read 0, writes ignored.
- Bits and nibbles for digits ≥ NUM_DIGITS: read 0, writes ignored.
- Reset values: VALUE=0, MODE=0, BLINK=0, BLANK = all ones in the implemented bits, all RAW=0, blink counter=0, phase=0, hex_out = all ones (display dark).
- Per-digit pattern, in priority order, with the result inverted onto hex_out:
  - BLANK[i] → 0x00.
  - BLINK[i] && phase → 0x00.
  - MODE[i] → RAW_i.
  - Otherwise decode(VALUE nibble i).
- Decode table (active-high, 0..F): 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- Blink counter: counts 0..BLINK_DIV-1 continuously. On reaching BLINK_DIV-1 it wraps to 0 and phase toggles.
- Any write to BLINK clears both the counter and phase on the same edge, so newly blinking digits start visible.
- readdata returns register contents for the current address, independent of chipselect.

## Timing
- A write at edge N updates the register at edge N.
- hex_out reflects the new value at edge N+1 (one-cycle registered output).
- readdata after edge N returns the new value combinationally.
- Phase toggle at edge T: affected digits change on hex_out at edge T+1.
- Blink write coinciding with counter wrap: the clear wins, so phase = 0 and the counter = 0.
- Reset mid-operation: all registers, the counter and hex_out take their reset values at the first edge with reset_n low. They hold those values while reset_n stays low.

## Configuration
- DNN_HEX_BLINK_EN defined: BLINK register, blink counter and phase are implemented as above.
- DNN_HEX_BLINK_EN undefined:
  - No counter is instantiated.
  - BLINK reads 0 and writes to it are ignored.
  - Phase is constant 0.
  - All other behaviour is unchanged.

## Structure
- Package dnn_hex_pkg holds:
  - register address constants (ADDR_VALUE, ADDR_MODE, ADDR_BLANK, ADDR_BLINK, ADDR_RAW_BASE);
  - the SEG_OFF constant (7'h7F, active-low dark);
  - the 16-entry decode table constant.
- Sub-module hex_seg_decoder: purely combinational, 4-bit nibble in → 7-bit active-high pattern out. It is instantiated NUM_DIGITS times.

## Test plan
- Reset, then release → hex_out all ones. Read addresses 0–3: 0, 0, 0x3F (NUM_DIGITS=6), 0.
- Write BLANK=0, VALUE=0x00FEDCBA. One cycle later, digits 0..5 read on hex_out: ~77, ~7C, ~39, ~5E, ~79, ~71, i.e. 0x08, 0x03, 0x46, 0x21, 0x06, 0x0E.
- Write RAW_2=0x49 and MODE=0x04 → digit 2 becomes 0x36 and the other digits are unchanged. Write address 14 (digit 6, beyond NUM_DIGITS) → ignored, reads 0.
- Run with BLINK_DIV=4 and blink enabled. Write BLINK=0x01 → digit 0 is visible for 4 cycles, dark (0x7F) for 4 cycles, periodic.
  - Rewrite BLINK mid-dark → digit 0 is visible from the next cycle.
- Assert reset_n low for one cycle mid-blink with non-zero registers → all registers return to reset values and hex_out returns to all ones at the following edge.
- Build without DNN_HEX_BLINK_EN: write BLINK=0xFF → reads 0 and no digit ever blanks.
